// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by every pipeline stage boundary.
//   - pipe_state_e : occupancy state of a stage register (EMPTY / ONE / TWO)
//   - CNT_W_DEF    : default width of the stall counter
//   - CTRL_*       : bit positions of the control bundle, so each boundary
//                    places alu_out_sel, jal, reg_jump, jump, dm2reg and
//                    pc_src identically.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int CNT_W_DEF  = 16;
    localparam int CTRL_W_DEF = 6;

    localparam int CTRL_ALU_OUT_SEL = 0;
    localparam int CTRL_JAL         = 1;
    localparam int CTRL_REG_JUMP    = 2;
    localparam int CTRL_JUMP        = 3;
    localparam int CTRL_DM2REG      = 4;
    localparam int CTRL_PC_SRC      = 5;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one entry of a pipeline stage (valid bit + control + payload).
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears everything)
//   load      : capture d_ctrl/d_data and mark the entry valid
//   clr       : drop the entry (valid=0); wins over load, payload is kept
//   d_ctrl    : control bundle to capture
//   d_data    : payload to capture
//   q_vld     : entry valid
//   q_ctrl    : control bundle, forced to zero while the entry is invalid
//   q_data    : payload, holds its last value while invalid
module pipe_slot #(
    parameter int CTRL_W = 6,
    parameter int PAY_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [PAY_W-1:0]  d_data,
    output logic              q_vld,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [PAY_W-1:0]  q_data
);

    logic              vld_q,  vld_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [PAY_W-1:0]  data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (load) begin
            vld_d  = 1'b1;
            ctrl_d = d_ctrl;
            data_d = d_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign q_vld  = vld_q;
    // A bubble must never present live control bits downstream.
    assign q_ctrl = vld_q ? ctrl_q : '0;
    assign q_data = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with optional
// two-entry skid buffer, flush-to-bubble and a saturating stall counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : squash held entries and any same-cycle input
//   in_valid   : upstream entry present
//   in_ready   : stage can accept (registered when SKID=1)
//   in_ctrl    : upstream control bundle
//   in_data    : upstream payload, word k at [k*DATA_W +: DATA_W]
//   out_valid  : downstream entry present
//   out_ready  : downstream accepts
//   out_ctrl   : control bundle, zero whenever out_valid=0
//   out_data   : payload, holds last value when invalid
//   stall_cnt  : saturating count of cycles with out_valid & !out_ready
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = 32,
    parameter int NCH    = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [NCH*DATA_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int PAY_W = NCH * DATA_W;

    pipe_state_e       state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              accept, emit;
    logic              main_load, main_clr, main_from_skid;
    logic              skid_load, skid_clr;
    logic              main_vld, skid_vld;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
    logic [PAY_W-1:0]  main_data, skid_data, main_data_in;

    // With the skid buffer in_ready comes from a flop, so out_ready never
    // reaches in_ready combinationally; without it the stage is a plain
    // register that can accept whenever its entry leaves this cycle.
    assign in_ready  = (SKID != 0) ? in_ready_q : (!main_vld || out_ready);
    assign accept    = in_valid && in_ready;
    assign emit      = main_vld && out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (SKID != 0) begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = TWO;
                    end else if (emit) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
                    end
                end
                TWO: begin
                    // Oldest entry leaves; the skid entry moves up behind it.
                    if (emit && skid_vld) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end else begin
            if (accept) begin
                main_load = 1'b1;
                state_d   = ONE;
            end else if (emit) begin
                main_clr = 1'b1;
                state_d  = EMPTY;
            end
        end
    end

    assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_data_in = main_from_skid ? skid_data : in_data;

    always_comb begin
        in_ready_d  = (state_d != TWO);
        stall_cnt_d = stall_cnt_q;
        if (main_vld && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clr    (main_clr),
        .d_ctrl (main_ctrl_in),
        .d_data (main_data_in),
        .q_vld  (main_vld),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    // Never loaded when SKID=0, so it stays empty and drops out in synthesis.
    pipe_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clr    (skid_clr),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_vld  (skid_vld),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
    );

    assign out_valid = main_vld;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Main DUT: defaults (SKID=1, CTRL_W=6, DATA_W=32, NCH=2, CNT_W=16)
    logic        rst, flush, iv, ir, ov, orr;
    logic [5:0]  ictrl, octrl;
    logic [63:0] idata, odata;
    logic [15:0] st;

    // SKID=0, NCH=3
    logic        f0, iv0, ir0, ov0, or0;
    logic [5:0]  ictrl0, octrl0;
    logic [95:0] idata0, odata0;
    logic [15:0] st0;

    // SKID=1, CNT_W=4
    logic        rst4, f4, iv4, ir4, ov4, or4;
    logic [5:0]  ictrl4, octrl4;
    logic [63:0] idata4, odata4;
    logic [3:0]  st4;

    pipe_stage_skid u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv), .in_ready(ir), .in_ctrl(ictrl), .in_data(idata),
        .out_valid(ov), .out_ready(orr), .out_ctrl(octrl), .out_data(odata),
        .stall_cnt(st)
    );

    pipe_stage_skid #(.SKID(0), .NCH(3)) u_dut0 (
        .clk(clk), .rst(rst), .flush(f0),
        .in_valid(iv0), .in_ready(ir0), .in_ctrl(ictrl0), .in_data(idata0),
        .out_valid(ov0), .out_ready(or0), .out_ctrl(octrl0), .out_data(odata0),
        .stall_cnt(st0)
    );

    pipe_stage_skid #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst4), .flush(f4),
        .in_valid(iv4), .in_ready(ir4), .in_ctrl(ictrl4), .in_data(idata4),
        .out_valid(ov4), .out_ready(or4), .out_ctrl(octrl4), .out_data(odata4),
        .stall_cnt(st4)
    );

    typedef struct {
        logic       iv;
        logic       orr;
        logic       fl;
        logic [5:0] ctrl;
        int         k;
        logic       ov;
        logic       ir;
        logic [5:0] ectrl;
        int         ek;
        int         est;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] mkd(input int k);
        return {32'(k + 256), 32'(k)};
    endfunction

    function automatic vec_t v(input logic i_v, input logic o_r, input logic fl,
                               input logic [5:0] c, input int k,
                               input logic e_ov, input logic e_ir,
                               input logic [5:0] e_c, input int e_k, input int e_st);
        vec_t r;
        r.iv = i_v; r.orr = o_r; r.fl = fl; r.ctrl = c; r.k = k;
        r.ov = e_ov; r.ir = e_ir; r.ectrl = e_c; r.ek = e_k; r.est = e_st;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [101:0] sb[$];
    logic [101:0] front;

    initial begin
        rst = 1'b1; flush = 1'b0; iv = 1'b0; orr = 1'b0; ictrl = '0; idata = '0;
        f0 = 1'b0; iv0 = 1'b0; or0 = 1'b0; ictrl0 = '0; idata0 = '0;
        rst4 = 1'b1; f4 = 1'b0; iv4 = 1'b0; or4 = 1'b0; ictrl4 = '0; idata4 = '0;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst4 = 1'b0;
        chk("rst ov",    128'(ov),    128'(0));
        chk("rst ctrl",  128'(octrl), 128'(0));
        chk("rst data",  128'(odata), 128'(0));
        chk("rst ir",    128'(ir),    128'(1));
        chk("rst stall", 128'(st),    128'(0));

        // iv orr fl ctrl k  | ov ir ectrl ek est
        tbl.push_back(v(1,1,0,6'h01, 1, 1,1,6'h01, 1,0)); // stream
        tbl.push_back(v(1,1,0,6'h02, 2, 1,1,6'h02, 2,0));
        tbl.push_back(v(1,1,0,6'h03, 3, 1,1,6'h03, 3,0));
        tbl.push_back(v(1,0,0,6'h04, 4, 1,0,6'h03, 3,1)); // 4 into skid
        tbl.push_back(v(1,0,0,6'h05, 5, 1,0,6'h03, 3,2)); // 5 held upstream
        tbl.push_back(v(1,0,0,6'h05, 5, 1,0,6'h03, 3,3));
        tbl.push_back(v(1,0,0,6'h05, 5, 1,0,6'h03, 3,4));
        tbl.push_back(v(1,1,0,6'h05, 5, 1,1,6'h04, 4,4)); // TWO -> ONE
        tbl.push_back(v(1,1,0,6'h05, 5, 1,1,6'h05, 5,4));
        tbl.push_back(v(0,1,0,6'h00, 0, 0,1,6'h00, 5,4)); // drain
        tbl.push_back(v(1,1,0,6'h3F, 6, 1,1,6'h3F, 6,4)); // bubble ctrl
        tbl.push_back(v(0,1,0,6'h00, 0, 0,1,6'h00, 6,4));
        tbl.push_back(v(0,1,0,6'h00, 0, 0,1,6'h00, 6,4));
        tbl.push_back(v(1,0,0,6'h07, 7, 1,1,6'h07, 7,4)); // build TWO
        tbl.push_back(v(1,0,0,6'h08, 8, 1,0,6'h07, 7,5));
        tbl.push_back(v(1,0,1,6'h09, 9, 0,1,6'h00, 7,6)); // flush + input
        tbl.push_back(v(0,1,0,6'h00, 0, 0,1,6'h00, 7,6));
        tbl.push_back(v(1,1,0,6'h0A,10, 1,1,6'h0A,10,6));
        tbl.push_back(v(0,1,0,6'h00, 0, 0,1,6'h00,10,6));

        foreach (tbl[i]) begin
            iv = tbl[i].iv; orr = tbl[i].orr; flush = tbl[i].fl;
            ictrl = tbl[i].ctrl; idata = mkd(tbl[i].k);
            @(posedge clk);
            #1;
            chk($sformatf("r%0d ov", i),    128'(ov),    128'(tbl[i].ov));
            chk($sformatf("r%0d ir", i),    128'(ir),    128'(tbl[i].ir));
            chk($sformatf("r%0d ctrl", i),  128'(octrl), 128'(tbl[i].ectrl));
            chk($sformatf("r%0d data", i),  128'(odata), 128'(mkd(tbl[i].ek)));
            chk($sformatf("r%0d stall", i), 128'(st),    128'(tbl[i].est));
        end
        iv = 1'b0; flush = 1'b0;
        chk("bubble dm2reg", 128'(octrl[CTRL_DM2REG]), 128'(0));
        chk("bubble jump",   128'(octrl[CTRL_JUMP]),   128'(0));

        // ---------------- counter saturation (CNT_W=4) ----------------
        iv4 = 1'b1; or4 = 1'b0; ictrl4 = 6'h15; idata4 = mkd(85);
        @(posedge clk); #1;
        iv4 = 1'b0;
        chk("sat load ov", 128'(ov4), 128'(1));
        chk("sat st0",     128'(st4), 128'(0));
        repeat (10) @(posedge clk);
        #1;
        chk("sat st10", 128'(st4), 128'(10));
        repeat (10) @(posedge clk);
        #1;
        chk("sat st20", 128'(st4), 128'(15));
        repeat (3) @(posedge clk);
        #1;
        chk("sat hold", 128'(st4), 128'(15));
        f4 = 1'b1;
        @(posedge clk); #1;
        f4 = 1'b0;
        chk("sat flush st", 128'(st4), 128'(15));
        chk("sat flush ov", 128'(ov4), 128'(0));
        chk("sat flush ir", 128'(ir4), 128'(1));
        iv4 = 1'b1; ictrl4 = 6'h2A; idata4 = mkd(42);
        @(posedge clk); #1;
        chk("reload ov",   128'(ov4),    128'(1));
        chk("reload ctrl", 128'(octrl4), 128'(6'h2A));
        // inputs during rst must be ignored, held entry discarded
        rst4 = 1'b1; ictrl4 = 6'h11; idata4 = mkd(17);
        @(posedge clk); #1;
        rst4 = 1'b0; iv4 = 1'b0;
        chk("rst4 st",   128'(st4),    128'(0));
        chk("rst4 ov",   128'(ov4),    128'(0));
        chk("rst4 ctrl", 128'(octrl4), 128'(0));
        chk("rst4 data", 128'(odata4), 128'(0));
        chk("rst4 ir",   128'(ir4),    128'(1));

        // ---------------- SKID=0 random vs scoreboard ----------------
        for (int c = 0; c < 1010; c++) begin
            if (c < 1000) begin
                iv0 = ($urandom_range(0, 3) != 0);
                or0 = ($urandom_range(0, 2) != 0);
            end else begin
                iv0 = 1'b0;
                or0 = 1'b1;
            end
            ictrl0 = 6'($urandom);
            idata0 = {$urandom, $urandom, $urandom};
            #1;
            chk($sformatf("c%0d ir0", c), 128'(ir0), 128'(!ov0 || or0));
            if (!ov0) chk($sformatf("c%0d bubble0", c), 128'(octrl0), 128'(0));
            if (ov0 && or0) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL c%0d sb: got emit expected no entry", c);
                end else begin
                    front = sb.pop_front();
                    chk($sformatf("c%0d ctrl0", c), 128'(octrl0), 128'(front[101:96]));
                    chk($sformatf("c%0d data0", c), 128'(odata0), 128'(front[95:0]));
                end
            end
            if (iv0 && ir0) sb.push_back({ictrl0, idata0});
            @(posedge clk);
            #1;
        end
        chk("sb empty",  128'(sb.size()), 128'(0));
        chk("ov0 drain", 128'(ov0),       128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
